// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline hazard controller.
//   state_e             : controller FSM states
//   REG_X0              : architectural zero register index (never a hazard source)
//   REDIRECT_CYCLES_DEF : default number of extra IF/ID flush cycles after a redirect
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_EX_WAIT  = 2'd1,
    S_REDIRECT = 2'd2
  } state_e;

  localparam logic [4:0]  REG_X0              = 5'd0;
  localparam int unsigned REDIRECT_CYCLES_DEF = 1;

endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// hazard_detect: combinational load-use comparator.
// Ports:
//   id_rs1, id_rs2            in  source registers of the ID instruction
//   id_rs1_used, id_rs2_used  in  ID instruction actually reads rs1/rs2
//   ex_rd                     in  destination of the EX instruction
//   ex_mem_read               in  EX instruction is a load
//   load_use                  out ID needs a value the EX load has not produced yet
module hazard_detect
  import pipe_ctrl_pkg::*;
(
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_rs1_used,
  input  logic       id_rs2_used,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  always_comb begin
    load_use = ex_mem_read && (ex_rd != REG_X0) &&
               ((id_rs1_used && (id_rs1 == ex_rd)) ||
                (id_rs2_used && (id_rs2 == ex_rd)));
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: hazard and sequencing controller for the 5-stage RV32 pipeline.
// Drives stall/flush of IF/ID, ID/EX, EX/MEM and the PC enable.
// Priority: redirect > multi-cycle EX > load-use > fetch bubble.
// Parameters:
//   REDIRECT_CYCLES  extra IF/ID flush cycles after a redirect (0..7)
// Ports:
//   clk, reset                      clock, synchronous active-high reset
//   id_rs1/id_rs2, *_used           ID source operands
//   ex_rd, ex_mem_read              EX destination / load flag
//   ex_redirect                     taken branch/jump resolved in EX
//   ex_busy, ex_done                multi-cycle EX op occupancy / last cycle
//   if_valid                        instruction memory data valid
//   pc_en, *_stall, *_flush         pipeline control outputs
//   stall_cnt, flush_cnt            performance counters
// Build option: define PIPE_HAZARD_PERF_EN to build the performance counters;
// otherwise both counter outputs are tied to zero.
module pipe_hazard_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned REDIRECT_CYCLES = REDIRECT_CYCLES_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rd,
  input  logic        ex_mem_read,
  input  logic        ex_redirect,
  input  logic        ex_busy,
  input  logic        ex_done,
  input  logic        if_valid,
  output logic        pc_en,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_flush,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [2:0] REDIR_LOAD = 3'(REDIRECT_CYCLES);

  state_e     state_q, state_d;
  logic [2:0] redir_cnt_q, redir_cnt_d;
  logic       load_use;
  logic       multi_cycle;

  hazard_detect u_hazard_detect (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_rs1_used (id_rs1_used),
    .id_rs2_used (id_rs2_used),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  // ex_done releases the stall in the same cycle it is seen.
  always_comb multi_cycle = ex_busy && !ex_done;

  // Control outputs: winning condition only, then the drain flush is ORed in
  // and any stall colliding with a flush on the same register is dropped.
  always_comb begin
    pc_en        = 1'b1;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_flush = 1'b0;
    if (reset) begin
      pc_en        = 1'b0;
      if_id_flush  = 1'b1;
      id_ex_flush  = 1'b1;
      ex_mem_flush = 1'b1;
    end else begin
      if (ex_redirect) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (multi_cycle) begin
        pc_en        = 1'b0;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_flush = 1'b1;
      end else if (load_use) begin
        pc_en       = 1'b0;
        if_id_stall = 1'b1;
        id_ex_flush = 1'b1;
      end else if (!if_valid) begin
        pc_en       = 1'b0;
        if_id_flush = 1'b1;
      end
      if (state_q == S_REDIRECT) if_id_flush = 1'b1;
      if (if_id_flush) if_id_stall = 1'b0;
      if (id_ex_flush) id_ex_stall = 1'b0;
    end
  end

  // Next state. The drain countdown keeps running while a multi-cycle op or
  // load-use is also present; a new redirect reloads it.
  always_comb begin
    state_d     = state_q;
    redir_cnt_d = redir_cnt_q;
    if (ex_redirect) begin
      if (REDIR_LOAD != 3'd0) begin
        state_d     = S_REDIRECT;
        redir_cnt_d = REDIR_LOAD;
      end else begin
        state_d     = S_RUN;
        redir_cnt_d = '0;
      end
    end else if (state_q == S_REDIRECT) begin
      if (redir_cnt_q > 3'd1) begin
        redir_cnt_d = redir_cnt_q - 3'd1;
      end else begin
        redir_cnt_d = '0;
        state_d     = multi_cycle ? S_EX_WAIT : S_RUN;
      end
    end else if (multi_cycle) begin
      state_d = S_EX_WAIT;
    end else begin
      state_d = S_RUN;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_RUN;
      redir_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      redir_cnt_q <= redir_cnt_d;
    end
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q + {31'd0, !pc_en};
    flush_cnt_d = flush_cnt_q + {31'd0, (if_id_flush || id_ex_flush)};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl (REDIRECT_CYCLES=2).
// Control vector order: {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush}
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic        id_rs1_used = 1'b0, id_rs2_used = 1'b0;
  logic        ex_mem_read = 1'b0, ex_redirect = 1'b0;
  logic        ex_busy = 1'b0, ex_done = 1'b0, if_valid = 1'b1;
  logic        pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush;
  logic [31:0] stall_cnt, flush_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  pipe_hazard_ctrl #(.REDIRECT_CYCLES(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rd        (ex_rd),
    .ex_mem_read  (ex_mem_read),
    .ex_redirect  (ex_redirect),
    .ex_busy      (ex_busy),
    .ex_done      (ex_done),
    .if_valid     (if_valid),
    .pc_en        (pc_en),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_flush (ex_mem_flush),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  typedef struct {
    string      name;
    logic       rst;
    logic [4:0] rs1;
    logic       rs1u;
    logic [4:0] rs2;
    logic       rs2u;
    logic [4:0] rd;
    logic       mr, redir, busy, done, ifv;
    logic [5:0] exp;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mkv(string n, logic rst, logic [4:0] rs1, logic rs1u,
                               logic [4:0] rs2, logic rs2u, logic [4:0] rd, logic mr,
                               logic redir, logic busy, logic done, logic ifv,
                               logic [5:0] exp);
    vec_t v;
    v.name = n; v.rst = rst; v.rs1 = rs1; v.rs1u = rs1u; v.rs2 = rs2; v.rs2u = rs2u;
    v.rd = rd; v.mr = mr; v.redir = redir; v.busy = busy; v.done = done; v.ifv = ifv;
    v.exp = exp;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    reset = v.rst; id_rs1 = v.rs1; id_rs1_used = v.rs1u; id_rs2 = v.rs2;
    id_rs2_used = v.rs2u; ex_rd = v.rd; ex_mem_read = v.mr; ex_redirect = v.redir;
    ex_busy = v.busy; ex_done = v.done; if_valid = v.ifv;
  endtask

  task automatic set_idle();
    reset = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rd = '0; ex_mem_read = 1'b0; ex_redirect = 1'b0; ex_busy = 1'b0;
    ex_done = 1'b0; if_valid = 1'b1;
  endtask

  task automatic set_load_use();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs2 = 5'd5; id_rs2_used = 1'b1;
  endtask

  task automatic check(input string name, input logic [5:0] exp);
    logic [5:0] got;
    #1;
    got = {pc_en, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_flush};
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b", name, got, exp);
    end
  endtask

  task automatic check_cnt(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    set_idle();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    //                 name             rst rs1 u  rs2 u  rd mr rd bs dn ifv  expected
    tbl[0]  = mkv("idle",           0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b100000);
    tbl[1]  = mkv("reset_out",      1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 6'b001011);
    tbl[2]  = mkv("lu_rs2",         0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 1, 6'b010010);
    tbl[3]  = mkv("lu_rd_x0",       0, 0, 0, 0, 1, 0, 1, 0, 0, 0, 1, 6'b100000);
    tbl[4]  = mkv("lu_rs1",         0, 7, 1, 0, 0, 7, 1, 0, 0, 0, 1, 6'b010010);
    tbl[5]  = mkv("lu_rs1_unused",  0, 7, 0, 3, 1, 7, 1, 0, 0, 0, 1, 6'b100000);
    tbl[6]  = mkv("no_load",        0, 7, 1, 0, 0, 7, 0, 0, 0, 0, 1, 6'b100000);
    tbl[7]  = mkv("multi",          0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 6'b010101);
    tbl[8]  = mkv("busy_done",      0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 6'b100000);
    tbl[9]  = mkv("done_no_busy",   0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 6'b100000);
    tbl[10] = mkv("fetch_bubble",   0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b001000);
    tbl[11] = mkv("redirect",       0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 6'b101010);
    tbl[12] = mkv("prio_all",       0, 0, 0, 5, 1, 5, 1, 1, 1, 0, 0, 6'b101010);
    tbl[13] = mkv("multi_over_lu",  0, 0, 0, 5, 1, 5, 1, 0, 1, 0, 1, 6'b010101);
    tbl[14] = mkv("lu_over_bubble", 0, 0, 0, 5, 1, 5, 1, 0, 0, 0, 0, 6'b010010);

    do_reset();

    // Single-cycle vectors, each from a fresh S_RUN.
    foreach (tbl[i]) begin
      do_reset();
      @(negedge clk);
      apply(tbl[i]);
      check(tbl[i].name, tbl[i].exp);
    end

    // Load-use lasts one cycle: the bubble then sits in EX.
    do_reset();
    @(negedge clk); set_idle(); set_load_use(); check("lu_seq_c1", 6'b010010);
    @(negedge clk); set_idle(); check("lu_seq_c2", 6'b100000);

    // Redirect drains for REDIRECT_CYCLES extra cycles.
    do_reset();
    @(negedge clk); set_idle(); ex_redirect = 1'b1; check("redir_c1", 6'b101010);
    @(negedge clk); set_idle(); check("redir_c2", 6'b101000);
    @(negedge clk); set_idle(); check("redir_c3", 6'b101000);
    @(negedge clk); set_idle(); check("redir_c4", 6'b100000);

    // A second redirect mid-drain reloads the countdown.
    do_reset();
    @(negedge clk); set_idle(); ex_redirect = 1'b1; check("reload_c1", 6'b101010);
    @(negedge clk); set_idle(); check("reload_c2", 6'b101000);
    @(negedge clk); set_idle(); ex_redirect = 1'b1; check("reload_c3", 6'b101010);
    @(negedge clk); set_idle(); check("reload_c4", 6'b101000);
    @(negedge clk); set_idle(); check("reload_c5", 6'b101000);
    @(negedge clk); set_idle(); check("reload_c6", 6'b100000);

    // Load-use during the drain: forced flush wins over the IF/ID stall.
    do_reset();
    @(negedge clk); set_idle(); ex_redirect = 1'b1; check("drain_lu_c1", 6'b101010);
    @(negedge clk); set_idle(); set_load_use(); check("drain_lu_c2", 6'b001010);
    @(negedge clk); set_idle(); check("drain_lu_c3", 6'b101000);
    @(negedge clk); set_idle(); check("drain_lu_c4", 6'b100000);

    // Five-cycle divide, ex_done on the fifth.
    do_reset();
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk); set_idle(); ex_busy = 1'b1; ex_done = (c == 5);
      check($sformatf("div_c%0d", c), (c < 5) ? 6'b010101 : 6'b100000);
    end
    @(negedge clk); set_idle(); check("div_after", 6'b100000);

    // Reset in cycle 2 of a divide.
    do_reset();
    @(negedge clk); set_idle(); ex_busy = 1'b1; check("rst_div_c1", 6'b010101);
    @(negedge clk); set_idle(); ex_busy = 1'b1; reset = 1'b1; check("rst_div_c2", 6'b001011);
    @(negedge clk); set_idle(); check("rst_div_c3", 6'b100000);

    // Reset during a drain leaves no residual flush.
    do_reset();
    @(negedge clk); set_idle(); ex_redirect = 1'b1; check("rst_redir_c1", 6'b101010);
    @(negedge clk); set_idle(); reset = 1'b1; check("rst_redir_c2", 6'b001011);
    @(negedge clk); set_idle(); check("rst_redir_c3", 6'b100000);

    // Performance counters: load-use scenario then redirect scenario.
    do_reset();
    check_cnt("stall_cnt_reset", stall_cnt, 32'd0);
    check_cnt("flush_cnt_reset", flush_cnt, 32'd0);
    @(negedge clk); set_idle(); set_load_use();
    @(negedge clk); set_idle();
    @(negedge clk); set_idle(); ex_redirect = 1'b1;
    @(negedge clk); set_idle();
    @(negedge clk); set_idle();
    @(negedge clk); set_idle();
    @(negedge clk); #1;
`ifdef PIPE_HAZARD_PERF_EN
    check_cnt("stall_cnt_perf", stall_cnt, 32'd1);
    check_cnt("flush_cnt_perf", flush_cnt, 32'd4);
`else
    check_cnt("stall_cnt_off", stall_cnt, 32'd0);
    check_cnt("flush_cnt_off", flush_cnt, 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central hazard and sequencing controller for the 5-stage RV32 pipeline. It drives the `stall`/`flush` inputs of the IF/ID, ID/EX and EX/MEM pipeline registers and the PC enable. It resolves load-use hazards, taken-branch/jump redirects, multi-cycle EX operations and fetch bubbles. It sits beside the datapath, takes decode/execute status in, and produces control out.

## Interface
- `REDIRECT_CYCLES`, 1: extra IF/ID flush cycles after a redirect, covering fetch latency; legal 0..7.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `id_rs1`, `id_rs2`  in  5 each  source registers of the instruction in ID.
- `id_rs1_used`, `id_rs2_used`  in  1 each  the ID instruction reads rs1/rs2.
- `ex_rd`  in  5  destination of the instruction in EX.
- `ex_mem_read`  in  1  the EX instruction is a load.
- `ex_redirect`  in  1  taken branch/jump resolved in EX this cycle.
- `ex_busy`  in  1  multi-cycle op (mul/div) occupies EX.
- `ex_done`  in  1  last cycle of the multi-cycle op; only meaningful with `ex_busy`.
- `if_valid`  in  1  instruction memory returned valid data this cycle.
- `pc_en`  out  1  PC register may update.
- `if_id_stall`, `if_id_flush`  out  1 each.
- `id_ex_stall`, `id_ex_flush`  out  1 each.
- `ex_mem_flush`  out  1.
- `stall_cnt`, `flush_cnt`  out  32 each  performance counters (see Configuration).

## Operation
- Outputs are combinational from the current inputs plus registered state (`state`, `redir_cnt`).
- FSM states:
  - `S_RUN`: normal operation.
  - `S_EX_WAIT`: a multi-cycle op is in EX.
  - `S_REDIRECT`: draining wrong-path fetches.
- Conditions:
  - **Redirect:** `ex_redirect`. Causes `if_id_flush=1` and `id_ex_flush=1`; PC loads the target, so `pc_en=1`. If `REDIRECT_CYCLES>0`: `redir_cnt<=REDIRECT_CYCLES`, next state `S_REDIRECT`.
  - **Multi-cycle:** `ex_busy & ~ex_done`. Causes `pc_en=0`, `if_id_stall=1`, `id_ex_stall=1`, `ex_mem_flush=1`; next state `S_EX_WAIT`. When `ex_done=1`, all of these are released in that same cycle and the next state is `S_RUN`.
  - **Load-use:** `ex_mem_read & ex_rd!=0 & ((id_rs1_used & id_rs1==ex_rd) | (id_rs2_used & id_rs2==ex_rd))`. Causes `pc_en=0`, `if_id_stall=1`, `id_ex_flush=1`. The resulting bubble clears the hazard, so it lasts exactly 1 cycle.
  - **Fetch bubble:** `~if_valid`, with no higher-priority condition active. Causes `pc_en=0`, `if_id_flush=1`.
- Priority: redirect > multi-cycle > load-use > fetch bubble. Only the winning condition's controls are asserted; all other outputs are 0.
- In `S_REDIRECT`:
  - `if_id_flush=1` each cycle and `redir_cnt` decrements; return to `S_RUN` when it reaches 1.
  - A new `ex_redirect` in this state reloads `redir_cnt`.
  - Multi-cycle and load-use conditions are still evaluated with normal priority. They are ORed with the forced flush, except that `if_id_stall` is suppressed whenever `if_id_flush=1`.
- A stall and a flush on the same register never both assert; flush wins.

## Timing
- Reset values:
  - `state=S_RUN`, `redir_cnt=0`, `stall_cnt=0`, `flush_cnt=0`.
  - While `reset=1`, combinational outputs are forced: `pc_en=0`, `if_id_flush=1`, `id_ex_flush=1`, `ex_mem_flush=1`, all stalls 0.
- Latency:
  - Hazard controls take effect in the same cycle as the triggering inputs (0-cycle latency).
  - State updates at the next rising edge.
- A redirect costs 2 squashed instructions plus `REDIRECT_CYCLES` bubbles.
- A load-use hazard costs 1 bubble.
- A multi-cycle op with N busy cycles, including the `ex_done` cycle, stalls for N-1 cycles.
- `ex_done` asserted without `ex_busy` is ignored.
- Reset asserted mid-`S_EX_WAIT` or mid-`S_REDIRECT` returns to `S_RUN` on the next edge; there is no residual countdown.

## Configuration
- `PIPE_HAZARD_PERF_EN`: performance counters.
  - Defined:
    - `stall_cnt` increments on every cycle with `pc_en=0` and `reset=0`.
    - `flush_cnt` increments on every cycle with `if_id_flush=1` or `id_ex_flush=1` and `reset=0`.
    - Both wrap at 2^32.
  - Undefined: both outputs are tied to 0 and no counter flops are built.

## Structure
- Shared package `pipe_ctrl_pkg`: the state enum (`S_RUN`, `S_EX_WAIT`, `S_REDIRECT`), the `REG_X0` constant, and the `REDIRECT_CYCLES` default.
- One sub-module, `hazard_detect`: a purely combinational load-use comparator producing `load_use`. The FSM and counters stay in the top module.

## Test plan
- Load-use: `ex_mem_read=1`, `ex_rd=5`, `id_rs2=5`, `id_rs2_used=1` → exactly 1 cycle with `pc_en=0`, `if_id_stall=1`, `id_ex_flush=1`. Same stimulus with `ex_rd=0` → no stall.
- Redirect with `REDIRECT_CYCLES=2`: `ex_redirect` pulse → `if_id_flush=1` for 3 consecutive cycles, `id_ex_flush=1` for the first cycle only, `pc_en=1` throughout.
- Divide: `ex_busy` held 5 cycles with `ex_done` in cycle 5 → `pc_en=0`, `id_ex_stall=1`, `ex_mem_flush=1` in cycles 1-4, all released in cycle 5.
- Priority: `ex_redirect`, `ex_busy` and load-use all asserted together → only the redirect outputs assert.
- Reset mid-op: assert `reset` in cycle 2 of a 5-cycle divide → reset outputs as specified; after release, `state=S_RUN` and no stall with `ex_busy=0`.
- Perf counters (with `PIPE_HAZARD_PERF_EN`): run the load-use scenario followed by the redirect scenario (`REDIRECT_CYCLES=2`) → `stall_cnt=1`, `flush_cnt=4`.
